// File: rtl/dds_core_if.sv
// ---------------------------------------------------------------------------
// dds_core_if
//
// Purpose: bundles the command side (tuning word, load strobe, run flag) and
// the DAC side (sample, valid) of the DDS engine into one connection.
//
// Signals:
//   en        - run flag: 1 = accumulate and emit samples, 0 = hold / midscale
//   m         - 32-bit tuning word, captured only while set is high
//   set       - single-cycle load strobe for the tuning word
//   dac_out   - unsigned sine sample for the R-2R DAC (OUT_W bits)
//   out_valid - dac_out carries a real sine sample
//
// Modports:
//   master - the command decoder / testbench side (drives en, m, set)
//   slave  - the DDS core side (drives dac_out, out_valid)
// ---------------------------------------------------------------------------
interface dds_core_if #(
  parameter int OUT_W = 8
);

  logic             en;
  logic [31:0]      m;
  logic             set;
  logic [OUT_W-1:0] dac_out;
  logic             out_valid;

  modport master (
    output en,
    output m,
    output set,
    input  dac_out,
    input  out_valid
  );

  modport slave (
    input  en,
    input  m,
    input  set,
    output dac_out,
    output out_valid
  );

endinterface

// File: rtl/dds_core.sv
// ---------------------------------------------------------------------------
// dds_core
//
// Purpose: phase-accumulator DDS engine feeding the on-board R-2R DAC. A
// 32-bit phase accumulator advances by the active tuning word every enabled
// clock; its top LUT_AW+2 bits address a quarter-wave sine table with
// quadrant folding, and a three-stage pipeline (address, table, sign) turns
// the phase into an unsigned OUT_W-bit sample. One sample per clock, no
// back-pressure.
//
// Parameters:
//   OUT_W  - DAC sample width; the table holds OUT_W-1 bit magnitudes
//   LUT_AW - quarter-wave table address width (2^LUT_AW entries)
//
// Ports:
//   clk    - system clock, everything on the rising edge
//   resetn - synchronous active-low reset, overrides every other input
//   bus    - dds_core_if slave modport (en, m, set in; dac_out, out_valid out)
//
// Build option:
//   PHASE_DITHER_EN - when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                     seed 0xACE1) is added, shifted left by 6, to the phase
//                     used for table addressing only. When undefined the phase
//                     is simply truncated and no LFSR exists.
// ---------------------------------------------------------------------------
module dds_core #(
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 8
) (
  input logic       clk,
  input logic       resetn,
  dds_core_if.slave bus
);

  localparam int LUT_N   = 1 << LUT_AW;
  localparam int PW      = LUT_AW + 2;
  localparam int MAG_MAX = (1 << (OUT_W - 1)) - 1;

  localparam logic [OUT_W-1:0] MID_V    = OUT_W'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0] MID_M1_V = OUT_W'((1 << (OUT_W - 1)) - 1);

  // Table entry i = round(MAG_MAX * sin(pi/2 * (i + 0.5) / LUT_N)), computed
  // with a fixed-point (Q30) Taylor series so the table is a pure constant
  // at elaboration time. The half-step offset keeps the quarter wave
  // symmetric, which is what lets mirroring by bit inversion work.
  function automatic logic [OUT_W-2:0] lutEntry(input int i);
    longint halfPi;
    longint x;
    longint x2;
    longint term;
    longint s;
    longint v;
    halfPi = 64'sd1686629713;
    x      = (halfPi * longint'(2 * i + 1)) / longint'(2 * LUT_N);
    x2     = (x * x) >>> 30;
    term   = x;
    s      = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    v = (longint'(MAG_MAX) * s + (64'sd1 <<< 29)) >>> 30;
    return v[OUT_W-2:0];
  endfunction

  // Constant quarter-wave table; read through a register in stage 2 so it
  // maps onto a ROM / block RAM.
  logic [OUT_W-2:0] lutRom [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : gLut
    assign lutRom[g] = lutEntry(g);
  end

  // Accumulator state: active tuning word, phase, and whether the phase just
  // registered was produced while running (carried down the pipeline).
  logic [31:0] mActive_q, mActive_d;
  logic [31:0] phase_q, phase_d;
  logic        phaseValid_q, phaseValid_d;

  // Stage 1 (address) registers.
  logic [LUT_AW-1:0] idx1_q, idx1_d;
  logic              quadHi1_q, quadHi1_d;
  logic              v1_q, v1_d;

  // Stage 2 (table) registers.
  logic [OUT_W-2:0] mag2_q, mag2_d;
  logic             quadHi2_q, quadHi2_d;
  logic             v2_q, v2_d;

  // Stage 3 (output) registers.
  logic [OUT_W-1:0] dacOut_q, dacOut_d;
  logic             outValid_q, outValid_d;

  // Truncated phase used for addressing.
  logic [PW-1:0] addrPhase;

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] ditherSum;

  // Free-running dither source: advances every clock regardless of en, so
  // the dither sequence never correlates with the run pattern.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // The LFSR state register; reseeded on reset so runs are repeatable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // The dither only perturbs which table entry is read; the accumulator
  // itself never sees it, so frequency accuracy is untouched.
  always_comb begin
    ditherSum = phase_q + {10'd0, lfsr_q, 6'd0};
    addrPhase = ditherSum[31 -: PW];
  end
`else
  // Plain truncation: the top PW phase bits pick the quadrant and entry.
  always_comb begin
    addrPhase = phase_q[31 -: PW];
  end
`endif

  // Accumulator next state. The add uses the tuning word that was active
  // before this edge, so a load coinciding with a run cycle only takes effect
  // from the following edge, and the phase is never disturbed by a load.
  always_comb begin
    mActive_d    = mActive_q;
    phase_d      = phase_q;
    phaseValid_d = bus.en;
    if (bus.set) begin
      mActive_d = bus.m;
    end
    if (bus.en) begin
      phase_d = phase_q + mActive_q;
    end
  end

  // Stage 1: split the phase into quadrant and table index. Odd quadrants run
  // the quarter wave backwards, which with the half-step table is exactly a
  // bitwise inversion of the index.
  always_comb begin
    logic [1:0]        quad;
    logic [LUT_AW-1:0] idxRaw;
    quad      = addrPhase[PW-1 -: 2];
    idxRaw    = addrPhase[LUT_AW-1:0];
    idx1_d    = quad[0] ? ~idxRaw : idxRaw;
    quadHi1_d = quad[1];
    v1_d      = phaseValid_q;
  end

  // Stage 2: table lookup, carrying the half-wave sign and valid bit along.
  always_comb begin
    mag2_d    = lutRom[idx1_q];
    quadHi2_d = quadHi1_q;
    v2_d      = v1_q;
  end

  // Stage 3: apply the sign around midscale. The upper half-wave sits at
  // MID+mag and the lower at (MID-1)-mag, so the full range is used without
  // any clipping. Samples not produced while running are forced to midscale.
  always_comb begin
    logic [OUT_W-1:0] magExt;
    magExt     = {1'b0, mag2_q};
    dacOut_d   = MID_V;
    outValid_d = v2_q;
    if (v2_q) begin
      dacOut_d = quadHi2_q ? (MID_M1_V - magExt) : (MID_V + magExt);
    end
  end

  // All state registers. Reset clears the accumulator and flushes the whole
  // pipeline in the same edge, so no stale sample survives a reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mActive_q    <= '0;
      phase_q      <= '0;
      phaseValid_q <= 1'b0;
      idx1_q       <= '0;
      quadHi1_q    <= 1'b0;
      v1_q         <= 1'b0;
      mag2_q       <= '0;
      quadHi2_q    <= 1'b0;
      v2_q         <= 1'b0;
      dacOut_q     <= MID_V;
      outValid_q   <= 1'b0;
    end else begin
      mActive_q    <= mActive_d;
      phase_q      <= phase_d;
      phaseValid_q <= phaseValid_d;
      idx1_q       <= idx1_d;
      quadHi1_q    <= quadHi1_d;
      v1_q         <= v1_d;
      mag2_q       <= mag2_d;
      quadHi2_q    <= quadHi2_d;
      v2_q         <= v2_d;
      dacOut_q     <= dacOut_d;
      outValid_q   <= outValid_d;
    end
  end

  assign bus.dac_out   = dacOut_q;
  assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_dds_core.sv
// ---------------------------------------------------------------------------
// tb_dds_core
//
// Purpose: self-checking bench for dds_core (default build, no dither).
// A behavioural model tracks the tuning word and phase as plain 32-bit
// arithmetic and records, for every clock edge, whether it was a reset edge,
// whether the engine was running, and the phase after the edge. The expected
// output after edge t follows directly from the edge t-3 record (three-cycle
// latency), unless a reset occurred in edges t-3..t, in which case the output
// is midscale and not valid. Samples are computed from the sine formula with
// real arithmetic.
// ---------------------------------------------------------------------------
module tb_dds_core;

  logic clk;
  logic resetn;

  dds_core_if #(.OUT_W(8)) bus ();

  dds_core #(
    .OUT_W (8),
    .LUT_AW(8)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          assertions = 0;
  int          failures   = 0;
  logic [31:0] mdlPhase   = '0;
  logic [31:0] mdlM       = '0;
  bit          histRst[$];
  bit          histRun[$];
  logic [31:0] histPh[$];

  // Ideal sample for a 32-bit phase: quadrant from the top two bits, the next
  // eight bits index a quarter wave (reversed in odd quadrants), and the lower
  // half-wave is mirrored below midscale.
  function automatic int sampleOf(input logic [31:0] p);
    int  q;
    int  k;
    int  mag;
    real ang;
    q = int'(p >> 30);
    k = int'((p >> 22) & 32'hFF);
    if ((q % 2) == 1) k = 255 - k;
    ang = 3.141592653589793 * (real'(k) + 0.5) / 512.0;
    mag = $rtoi(127.0 * $sin(ang) + 0.5);
    return (q < 2) ? (128 + mag) : (127 - mag);
  endfunction

  // Compare the DUT outputs just after the latest edge with the model.
  task automatic checkOutput(input string tag);
    int         t;
    bit         flushed;
    logic [7:0] expD;
    logic       expV;
    t       = histRst.size() - 1;
    flushed = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if ((t - k) < 0) flushed = 1'b1;
      else if (histRst[t-k]) flushed = 1'b1;
    end
    if (flushed || !histRun[t-3]) begin
      expD = 8'd128;
      expV = 1'b0;
    end else begin
      expD = 8'(sampleOf(histPh[t-3]));
      expV = 1'b1;
    end
    assertions++;
    assert (bus.dac_out === expD) else begin
      failures++;
      $error("[TB] FAIL %s dac_out cycle %0d: got %0d expected %0d", tag, t, bus.dac_out, expD);
    end
    assertions++;
    assert (bus.out_valid === expV) else begin
      failures++;
      $error("[TB] FAIL %s out_valid cycle %0d: got %0b expected %0b", tag, t, bus.out_valid, expV);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input bit rn, input bit e, input bit s,
                               input logic [31:0] mv, input string tag);
    resetn  = rn;
    bus.en  = e;
    bus.set = s;
    bus.m   = mv;
    @(posedge clk);
    if (!rn) begin
      mdlPhase = '0;
      mdlM     = '0;
    end else begin
      if (e) mdlPhase = mdlPhase + mdlM;
      if (s) mdlM = mv;
    end
    histRst.push_back(!rn);
    histRun.push_back(rn && e);
    histPh.push_back(mdlPhase);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    resetn  = 1'b0;
    bus.en  = 1'b0;
    bus.set = 1'b0;
    bus.m   = '0;

    // Reset dominates en/set/m.
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, "reset");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, "idle");

    // Quadrant sweep: 255, 127, 0, 128 repeating.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h4000_0000, "sweepload");
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, "sweep");

    // Mid-run reset, then running with a zero tuning word.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, "midreset");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, "postreset");

    // Phase-continuous retune with set coinciding with a run cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0100_0000, "retuneload");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, "retune1");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0200_0000, "retuneset");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, "retune2");

    // Disable: drain then midscale; re-enable resumes from frozen phase.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, "disable");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, "resume");

    // Wrap-around: counting down modulo 2^32.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "wrapreset");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, "wrapload");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, "wrap");

    // Full table scan: every one of the 1024 addressable phases once.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "scanreset");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0000, "scanload");
    for (int i = 0; i < 1030; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, "lutscan");

    // Randomised traffic with occasional resets and retunes.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0), $urandom, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/dds_core.md
# dds_core

Phase-accumulator DDS engine driving the on-board R-2R DAC. Sits directly downstream of the UART command decoder: it takes the 32-bit tuning word `m`, the load strobe `set` and the run flag `en`, and produces an 8-bit unsigned sine sample every clock. A quarter-wave LUT with quadrant folding keeps ROM small. A three-stage output pipeline holds timing at the board clock.

## Interface
- `OUT_W`, 8: DAC sample width. The LUT holds `OUT_W-1`-bit magnitudes.
- `LUT_AW`, 8: quarter-wave LUT address width, giving 256 entries. Phase is truncated to `LUT_AW+2` bits.
- `clk` input 1: system clock. All logic is on the rising edge.
- `resetn` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `en` input 1: level. 1 = accumulate and output; 0 = hold phase and output midscale.
- `m` input 32: tuning word (frequency = m·f_clk/2^32). Sampled only when `set`=1.
- `set` input 1: single-cycle strobe that loads `m` into the active tuning register.
- `dac_out` output OUT_W: unsigned sample. Midscale is 2^(OUT_W-1) = 128.
- `out_valid` output 1: `dac_out` carries a sine sample (derived from `en`).

## Operation
- Reset (`resetn`=0 at an edge): `m_active`=0, `phase`=0, all pipeline registers cleared, `dac_out`=128, `out_valid`=0. Reset overrides every other input in the same cycle.
- Tuning load: at an edge with `set`=1, `m_active` <= `m`. The phase is not touched, so frequency changes are phase-continuous. `set` held high for several cycles reloads on every cycle (harmless).
- Accumulator: at an edge with `en`=1, `phase` <= (`phase` + `m_active`) mod 2^32. Wrap-around is silent. At an edge with `en`=0, `phase` holds.
- Simultaneous `set` and `en`: the accumulation in that cycle uses the old `m_active`. The new word takes effect from the next edge.
- Pipeline stage 1 (address): `quad` = p[31:30]; `idx` = p[29:22], or ~p[29:22] when quad[0]=1 (mirrored quarter). `en` is carried alongside as `v1`.
- Pipeline stage 2 (LUT): `mag` <= LUT[idx], where LUT[i] = round(127·sin(π/2·(i+0.5)/256)). So LUT[0]=0 and LUT[255]=127. `quad[1]` and `v1` are carried forward.
- Pipeline stage 3 (output):
  - Sign applied: `dac_out` <= 128+`mag` when quad[1]=0, else 127−`mag`. The result range is 0..255, so no clipping is needed.
  - If the carried valid bit is 0, `dac_out` <= 128 instead.
  - `out_valid` <= carried valid bit.
- The LUT is an initialised ROM (inferred block RAM). Contents are fixed at synthesis.

## Timing
- Phase P registered at edge k, with `en`=1 at edge k → `dac_out`/`out_valid` reflecting P are updated at edge k+3.
- Load latency: `set` at edge k → `m_active` is valid after edge k. The first increment using it is at edge k+1.
- `en` 1→0 sampled at edge k: the last accumulation is at edge k−1. Samples of already-issued phases drain normally. From edge k+3, `dac_out`=128 and `out_valid`=0.
- `en` 0→1 at edge k: the first increment is at edge k. `out_valid` rises at edge k+3.
- Reset mid-operation: the pipeline flushes in that same edge. There is no partial sample and no stale data after `resetn` returns high.
- Throughput: one sample per clock. There is no stall or back-pressure.

## Configuration
- `PHASE_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset) advances every clock.
  - Its value, shifted left by 6, is added to `phase` in stage 1 before truncation. The sum is used only for addressing; the accumulator itself is unaffected.
  - Dither does not alter reset values or latency.
- `PHASE_DITHER_EN` undefined: plain truncation of p[31:22]. No LFSR is built. All test-plan values below assume the macro is undefined.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with `en`=1, `set`=1, `m`=0xFFFFFFFF → `dac_out`=128, `out_valid`=0, `phase`=0 throughout.
- Quadrant sweep: `set` with `m`=0x40000000, then `en`=1 → after 3-cycle latency `dac_out` repeats 128, 255, 127, 0; `out_valid`=1.
- Phase-continuous retune:
  - Run with `m`=0x01000000 for 10 cycles, then `set` with `m`=0x02000000 in the same cycle as `en`=1.
  - → phase steps 0x01000000 in that cycle and 0x02000000 from the next cycle, with no phase jump.
- Disable: drop `en` mid-run → `phase` frozen at its last value. Three further samples drain, then `dac_out`=128 and `out_valid`=0. Re-assert `en` → resumes from the frozen phase.
- Wrap-around: `m`=0xFFFFFFFF from `phase`=0 → `phase` = 0xFFFFFFFF, 0xFFFFFFFE, … (counts down modulo 2^32, no error).
- Mid-run reset: assert `resetn`=0 for 1 cycle during the sweep → next-edge outputs are 128/0. After release, with `en`=1, `m_active`=0 → `phase` stays 0 and `dac_out` settles to 128 (LUT[0]=0) with `out_valid`=1.
